// File: rtl/rgmii2gmii.sv
// rgmii2gmii: RGMII receive path, DDR sample pairs to GMII bytes.
// Takes the rise and fall samples captured by the RX IO cells and rebuilds GMII bytes.
// In 1000 mode each clock carries one full byte. In 10/100 mode each clock carries one nibble.
// Also recovers RX_ER and keeps saturating frame and error counters.
// Optional feature: define RGMII_RX_INBAND_STATUS_EN to decode the in-band link status
// carried in idle cycles. When it is undefined, the link_* outputs are tied to zero.

module rgmii2gmii #(
    parameter int CNT_W      = 16,
    parameter int STS_FILTER = 4
) (
    input  logic             gmii_clk,
    input  logic             reset,
    input  logic [4:0]       ddr_hi,
    input  logic [4:0]       ddr_lo,
    input  logic             spd_1000,
    output logic             gmii_den,
    output logic             gmii_ce,
    output logic             gmii_er,
    output logic [7:0]       gmii_dout,
    output logic             align_err,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             link_up,
    output logic [1:0]       link_speed,
    output logic             link_fdx
);

    logic             w_dv;
    logic             w_er;
    logic             w_take;
    logic             w_frame_end;

    logic             r_armed;
    logic             r_in_frame;
    logic             r_phase;
    logic             r_frame_err;
    logic             r_nib_er;
    logic [3:0]       r_nib_lo;
    logic             r_den;
    logic             r_ce;
    logic             r_er;
    logic             r_align_err;
    logic [7:0]       r_dout;
    logic [CNT_W-1:0] r_frame_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    // Saturating increment: the counter sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_W'(1);
        end
    endfunction

    // The control line carries DV on the rising phase and DV^ER on the falling phase.
    assign w_dv        = ddr_hi[4];
    assign w_er        = ddr_hi[4] ^ ddr_lo[4];
    // Data is accepted only once the receiver has seen an idle cycle after reset.
    assign w_take      = r_armed & w_dv;
    assign w_frame_end = r_in_frame & ~w_dv;

    // Byte assembly, frame tracking and the saturating counters.
    always_ff @(posedge gmii_clk) begin
        if (reset) begin
            r_armed     <= 1'b0;
            r_in_frame  <= 1'b0;
            r_phase     <= 1'b0;
            r_frame_err <= 1'b0;
            r_nib_er    <= 1'b0;
            r_nib_lo    <= 4'h0;
            r_den       <= 1'b0;
            r_ce        <= 1'b0;
            r_er        <= 1'b0;
            r_align_err <= 1'b0;
            r_dout      <= 8'h00;
            r_frame_cnt <= {CNT_W{1'b0}};
            r_err_cnt   <= {CNT_W{1'b0}};
        end else begin
            if (!w_dv) begin
                r_armed <= 1'b1;
            end
            r_in_frame <= w_take;
            if (w_take) begin
                r_den       <= 1'b1;
                r_frame_err <= r_in_frame ? (r_frame_err | w_er) : w_er;
                if (spd_1000) begin
                    // The rising-phase nibble goes to the upper half, matching the TX mapping.
                    r_dout  <= {ddr_hi[3:0], ddr_lo[3:0]};
                    r_ce    <= 1'b1;
                    r_er    <= w_er;
                    r_phase <= 1'b0;
                end else if (!r_phase) begin
                    r_nib_lo <= ddr_hi[3:0];
                    r_nib_er <= w_er;
                    r_phase  <= 1'b1;
                    r_ce     <= 1'b0;
                    r_er     <= 1'b0;
                end else begin
                    r_dout  <= {ddr_hi[3:0], r_nib_lo};
                    r_er    <= r_nib_er | w_er;
                    r_ce    <= 1'b1;
                    r_phase <= 1'b0;
                end
            end else begin
                r_den   <= 1'b0;
                r_ce    <= 1'b0;
                r_er    <= 1'b0;
                r_phase <= 1'b0;
            end
            // A pending low nibble when DV drops means the frame ended on an odd nibble.
            r_align_err <= w_frame_end & r_phase;
            if (w_frame_end) begin
                r_frame_cnt <= sat_inc(r_frame_cnt);
                if (r_frame_err | r_phase) begin
                    r_err_cnt <= sat_inc(r_err_cnt);
                end
            end
        end
    end

    assign gmii_den  = r_den;
    assign gmii_ce   = r_ce;
    assign gmii_er   = r_er;
    assign gmii_dout = r_dout;
    assign align_err = r_align_err;
    assign frame_cnt = r_frame_cnt;
    assign err_cnt   = r_err_cnt;

`ifdef RGMII_RX_INBAND_STATUS_EN
    localparam int              SF_W    = $clog2(STS_FILTER + 1);
    localparam logic [SF_W-1:0] SF_FULL = SF_W'(STS_FILTER);

    logic            w_idle;
    logic            w_sts_match;
    logic [SF_W-1:0] w_sts_next;
    logic [3:0]      r_sts_cand;
    logic [SF_W-1:0] r_sts_cnt;
    logic            r_link_up;
    logic [1:0]      r_link_speed;
    logic            r_link_fdx;

    // Length of the run of identical idle status samples, including the current one.
    always_comb begin
        w_idle      = ~w_dv & ~w_er;
        w_sts_match = (r_sts_cnt != {SF_W{1'b0}}) && (ddr_hi[3:0] == r_sts_cand);
        if (!w_sts_match) begin
            w_sts_next = SF_W'(1);
        end else if (r_sts_cnt == SF_FULL) begin
            w_sts_next = SF_FULL;
        end else begin
            w_sts_next = r_sts_cnt + SF_W'(1);
        end
    end

    // The status filter only advances on idle cycles. Non-idle cycles leave it unchanged.
    always_ff @(posedge gmii_clk) begin
        if (reset) begin
            r_sts_cand   <= 4'h0;
            r_sts_cnt    <= {SF_W{1'b0}};
            r_link_up    <= 1'b0;
            r_link_speed <= 2'b00;
            r_link_fdx   <= 1'b0;
        end else if (w_idle) begin
            r_sts_cand <= ddr_hi[3:0];
            r_sts_cnt  <= w_sts_next;
            if (w_sts_next == SF_FULL) begin
                r_link_fdx   <= ddr_hi[3];
                r_link_speed <= ddr_hi[2:1];
                r_link_up    <= ddr_hi[0];
            end
        end
    end

    assign link_up    = r_link_up;
    assign link_speed = r_link_speed;
    assign link_fdx   = r_link_fdx;
`else
    // Status decode is compiled out, so the link outputs are held at zero.
    assign {link_fdx, link_speed, link_up} = 4'(STS_FILTER) & 4'b0000;
`endif

endmodule

// File: tb/tb_rgmii2gmii.sv
// Self-checking bench for rgmii2gmii with randomized frames and a behavioural reference model.
module tb_rgmii2gmii;

    localparam int CNT_W = 4;
    localparam int STS_F = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             gmii_clk = 1'b0;
    logic             reset;
    logic [4:0]       ddr_hi;
    logic [4:0]       ddr_lo;
    logic             spd_1000;
    logic             gmii_den, gmii_ce, gmii_er, align_err;
    logic [7:0]       gmii_dout;
    logic [CNT_W-1:0] frame_cnt, err_cnt;
    logic             link_up, link_fdx;
    logic [1:0]       link_speed;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state.
    int         exp_frames;
    int         exp_errs;
    logic [3:0] idle_hist[$];
    logic [3:0] exp_sts;
    logic [3:0] idle_nib;

    // Stimulus queues and captured DUT observations.
    logic [7:0] tx_d[$];
    bit         tx_e[$];
    logic [7:0] got_b[$];
    logic       got_e[$];
    int         got_pos[$];
    int         got_align, align_pos, den_cycles;

    rgmii2gmii #(.CNT_W(CNT_W), .STS_FILTER(STS_F)) dut (
        .gmii_clk(gmii_clk), .reset(reset), .ddr_hi(ddr_hi), .ddr_lo(ddr_lo),
        .spd_1000(spd_1000), .gmii_den(gmii_den), .gmii_ce(gmii_ce), .gmii_er(gmii_er),
        .gmii_dout(gmii_dout), .align_err(align_err), .frame_cnt(frame_cnt),
        .err_cnt(err_cnt), .link_up(link_up), .link_speed(link_speed), .link_fdx(link_fdx)
    );

    always #5 gmii_clk = ~gmii_clk;

    // Drive one clock of DDR samples. Returns at the next falling edge, when outputs are settled.
    // The status model keeps every idle sample. The expected status becomes the latest value
    // whose last STS_F idle samples are all equal.
    task automatic step(input logic [4:0] hi, input logic [4:0] lo);
        ddr_hi = hi;
        ddr_lo = lo;
        @(posedge gmii_clk);
        if (reset) begin
            idle_hist.delete();
            exp_sts = 4'h0;
        end else if (!hi[4] && !lo[4]) begin
            idle_hist.push_back(hi[3:0]);
`ifdef RGMII_RX_INBAND_STATUS_EN
            if (idle_hist.size() >= STS_F) begin
                bit same = 1'b1;
                for (int k = 1; k < STS_F; k++)
                    if (idle_hist[idle_hist.size() - 1 - k] != hi[3:0]) same = 1'b0;
                if (same) exp_sts = hi[3:0];
            end
`endif
        end
        @(negedge gmii_clk);
    endtask

    // Send tx_d/tx_e as one frame followed by 3 idle cycles and record what comes out.
    // Also updates the model counters.
    task automatic run_frame(input bit m1000);
        bit bad;
        got_b.delete(); got_e.delete(); got_pos.delete();
        got_align = 0; align_pos = -1; den_cycles = 0;
        spd_1000 = m1000;
        for (int i = 0; i < tx_d.size(); i++) begin
            step({1'b1, m1000 ? tx_d[i][7:4] : tx_d[i][3:0]},
                 {1'b1 ^ tx_e[i], m1000 ? tx_d[i][3:0] : tx_d[i][7:4]});
            if (gmii_den) den_cycles++;
            if (gmii_ce) begin got_b.push_back(gmii_dout); got_e.push_back(gmii_er); got_pos.push_back(i); end
            if (align_err) begin got_align++; align_pos = i; end
        end
        for (int j = 0; j < 3; j++) begin
            step({1'b0, idle_nib}, 5'h00);
            if (gmii_den) den_cycles++;
            if (gmii_ce) begin got_b.push_back(gmii_dout); got_e.push_back(gmii_er); got_pos.push_back(tx_d.size() + j); end
            if (align_err) begin got_align++; align_pos = j; end
        end
        bad = (!m1000 && (tx_d.size() % 2 == 1));
        foreach (tx_e[i]) if (tx_e[i]) bad = 1'b1;
        exp_frames = (exp_frames < CMAX) ? exp_frames + 1 : CMAX;
        if (bad) exp_errs = (exp_errs < CMAX) ? exp_errs + 1 : CMAX;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(5'h00, 5'h00);
        step(5'h1A, 5'h05);
        n_total++;
        if ({gmii_den, gmii_ce, gmii_er, align_err, gmii_dout} !== 12'h000)
            $display("FAIL reset_outputs: got den/ce/er/align/dout=%b%b%b%b/%h want 0", gmii_den, gmii_ce, gmii_er, align_err, gmii_dout);
        else n_pass++;
        n_total++;
        if (frame_cnt !== CNT_W'(0) || err_cnt !== CNT_W'(0))
            $display("FAIL reset_counters: got %0d/%0d want 0/0", frame_cnt, err_cnt);
        else n_pass++;
        n_total++;
        if ({link_fdx, link_speed, link_up} !== 4'h0)
            $display("FAIL reset_link: got %h want 0", {link_fdx, link_speed, link_up});
        else n_pass++;
        reset = 1'b0;
        step(5'h00, 5'h00);
    endtask

    // 1000 mode: kind 0 = ramp 0x00..0x3F; kind 1 = ramp with an error on byte 10; else random.
    task automatic test_gmii_1000(input int kind);
        int n;
        tx_d.delete(); tx_e.delete();
        n = (kind < 2) ? 64 : $urandom_range(1, 40);
        for (int i = 0; i < n; i++) begin
            tx_d.push_back((kind < 2) ? 8'(i) : 8'($urandom));
            tx_e.push_back((kind == 1) ? (i == 10) : ((kind > 1) && ($urandom_range(0, 9) == 0)));
        end
        run_frame(1'b1);
        n_total++;
        if (got_b.size() !== n) $display("FAIL g1000_count: got %0d bytes want %0d", got_b.size(), n);
        else n_pass++;
        for (int i = 0; i < n && i < got_b.size(); i++) begin
            n_total++;
            if (got_b[i] !== tx_d[i] || got_e[i] !== tx_e[i] || got_pos[i] !== i)
                $display("FAIL g1000_byte%0d: got %h er%b @%0d want %h er%b @%0d", i, got_b[i], got_e[i], got_pos[i], tx_d[i], tx_e[i], i);
            else n_pass++;
        end
        n_total++;
        if (den_cycles !== n || got_align !== 0)
            $display("FAIL g1000_den_align: got den=%0d align=%0d want %0d/0", den_cycles, got_align, n);
        else n_pass++;
        n_total++;
        if (frame_cnt !== CNT_W'(exp_frames) || err_cnt !== CNT_W'(exp_errs))
            $display("FAIL g1000_counters: got %0d/%0d want %0d/%0d", frame_cnt, err_cnt, exp_frames, exp_errs);
        else n_pass++;
    endtask

    // 10/100 mode: kind 0 = preamble+SFD; kind 1 = 9 random nibbles; else random length and errors.
    task automatic test_nibble(input int kind);
        int n, nb;
        logic [7:0] eb;
        logic       ee;
        tx_d.delete(); tx_e.delete();
        n = (kind == 0) ? 16 : (kind == 1) ? 9 : $urandom_range(1, 30);
        for (int i = 0; i < n; i++) begin
            tx_d.push_back({4'($urandom), (kind == 0) ? ((i == 15) ? 4'hD : 4'h5) : 4'($urandom)});
            tx_e.push_back((kind > 1) && ($urandom_range(0, 7) == 0));
        end
        run_frame(1'b0);
        nb = n / 2;
        n_total++;
        if (got_b.size() !== nb) $display("FAIL nib_count: got %0d bytes want %0d", got_b.size(), nb);
        else n_pass++;
        for (int k = 0; k < nb && k < got_b.size(); k++) begin
            eb = {tx_d[2*k+1][3:0], tx_d[2*k][3:0]};
            ee = tx_e[2*k] | tx_e[2*k+1];
            n_total++;
            if (got_b[k] !== eb || got_e[k] !== ee || got_pos[k] !== 2*k+1)
                $display("FAIL nib_byte%0d: got %h er%b @%0d want %h er%b @%0d", k, got_b[k], got_e[k], got_pos[k], eb, ee, 2*k+1);
            else n_pass++;
        end
        n_total++;
        if (got_align !== (n % 2) || ((n % 2) == 1 && align_pos !== 0))
            $display("FAIL nib_align: got %0d pulses @%0d want %0d @0", got_align, align_pos, n % 2);
        else n_pass++;
        n_total++;
        if (den_cycles !== n) $display("FAIL nib_den: got %0d want %0d", den_cycles, n);
        else n_pass++;
        n_total++;
        if (frame_cnt !== CNT_W'(exp_frames) || err_cnt !== CNT_W'(exp_errs))
            $display("FAIL nib_counters: got %0d/%0d want %0d/%0d", frame_cnt, err_cnt, exp_frames, exp_errs);
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        spd_1000 = 1'b1;
        for (int i = 0; i < 3; i++) step({1'b1, 4'($urandom)}, {1'b1, 4'($urandom)});
        reset = 1'b1;
        exp_frames = 0; exp_errs = 0;
        step({1'b1, 4'h3}, {1'b1, 4'h4});
        n_total++;
        if ({gmii_den, gmii_ce, gmii_er} !== 3'b000 || frame_cnt !== CNT_W'(0) || err_cnt !== CNT_W'(0))
            $display("FAIL midreset_clear: got den%b ce%b er%b cnt %0d/%0d want all 0", gmii_den, gmii_ce, gmii_er, frame_cnt, err_cnt);
        else n_pass++;
        step({1'b1, 4'h5}, {1'b1, 4'h6});
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step({1'b1, 4'($urandom)}, {1'b1, 4'($urandom)});
            n_total++;
            if (gmii_den !== 1'b0 || gmii_ce !== 1'b0)
                $display("FAIL midreset_ignored%0d: got den%b ce%b want 0 0", i, gmii_den, gmii_ce);
            else n_pass++;
        end
        step(5'h00, 5'h00);
        n_total++;
        if (frame_cnt !== CNT_W'(0)) $display("FAIL midreset_nocount: got %0d want 0", frame_cnt);
        else n_pass++;
        tx_d.delete(); tx_e.delete();
        for (int i = 0; i < 5; i++) begin tx_d.push_back(8'($urandom)); tx_e.push_back(1'b0); end
        run_frame(1'b1);
        n_total++;
        if (got_b.size() !== 5 || frame_cnt !== CNT_W'(exp_frames))
            $display("FAIL midreset_next: got %0d bytes cnt %0d want 5 bytes cnt %0d", got_b.size(), frame_cnt, exp_frames);
        else n_pass++;
    endtask

    task automatic test_saturation();
        for (int f = 0; f < 30; f++) begin
            tx_d.delete(); tx_e.delete();
            for (int i = 0; i < $urandom_range(1, 4); i++) begin
                tx_d.push_back(8'($urandom));
                tx_e.push_back((f % 3 != 2) && (i == 0));
            end
            run_frame(1'b1);
            n_total++;
            if (frame_cnt !== CNT_W'(exp_frames) || err_cnt !== CNT_W'(exp_errs))
                $display("FAIL sat_frame%0d: got %0d/%0d want %0d/%0d", f, frame_cnt, err_cnt, exp_frames, exp_errs);
            else n_pass++;
        end
        n_total++;
        if (frame_cnt !== CNT_W'(CMAX) || err_cnt !== CNT_W'(CMAX))
            $display("FAIL sat_max: got %0d/%0d want %0d/%0d", frame_cnt, err_cnt, CMAX, CMAX);
        else n_pass++;
    endtask

    // Idle status sequences. Bit 4 of an entry marks a non-idle cycle (dv=0, er=1).
    task automatic test_status();
        logic [4:0] seq [0:19] = '{5'h05, 5'h05, 5'h05, 5'h06, 5'h0D, 5'h0D, 5'h0D, 5'h0D,
                                   5'h0B, 5'h0B, 5'h1B, 5'h0B, 5'h00, 5'h0B, 5'h0D, 5'h0D,
                                   5'h0D, 5'h00, 5'h00, 5'h00};
        logic [3:0] nib;
        for (int i = 0; i < 20; i++) begin
            step({1'b0, seq[i][3:0]}, {seq[i][4], 4'h0});
            n_total++;
            if ({link_fdx, link_speed, link_up} !== exp_sts)
                $display("FAIL status_seq%0d: got %h want %h", i, {link_fdx, link_speed, link_up}, exp_sts);
            else n_pass++;
        end
        for (int r = 0; r < 10; r++) begin
            nib = ($urandom_range(0, 2) == 0) ? 4'h2 : (($urandom_range(0, 1) == 0) ? 4'hD : 4'hA);
            for (int k = 0; k < $urandom_range(1, 6); k++) begin
                step({1'b0, nib}, {($urandom_range(0, 5) == 0), 4'h0});
                n_total++;
                if ({link_fdx, link_speed, link_up} !== exp_sts)
                    $display("FAIL status_rand%0d_%0d: got %h want %h", r, k, {link_fdx, link_speed, link_up}, exp_sts);
                else n_pass++;
            end
        end
    endtask

    initial begin
        reset = 1'b1; spd_1000 = 1'b1; ddr_hi = 5'h00; ddr_lo = 5'h00;
        idle_nib = 4'h0; exp_frames = 0; exp_errs = 0; exp_sts = 4'h0;
        test_reset();
        test_gmii_1000(0);
        test_gmii_1000(1);
        for (int r = 0; r < 4; r++) test_gmii_1000(2);
        test_nibble(0);
        test_nibble(1);
        for (int r = 0; r < 4; r++) test_nibble(2);
        test_gmii_1000(2);
        test_reset_midframe();
        test_saturation();
        test_status();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
